// File: rtl/szcv_flag_reg_if.sv
// Bus bundle between the decode/ALU stage and the SZCV flag register.
// The master side drives ALU and control inputs; the slave side returns flags and branch decision.
interface szcv_flag_reg_if #(
  parameter int WIDTH = 16
);
  logic             szcv_enable;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             flag_save;
  logic             flag_restore;
  logic             eval_en;
  logic [2:0]       cond;
  logic [3:0]       flags;
  logic             shadow_valid;
  logic             branch_taken;

  modport master (
    output szcv_enable, alu_op, alu_a, alu_b, alu_result, alu_carry,
    output flag_save, flag_restore, eval_en, cond,
    input  flags, shadow_valid, branch_taken
  );

  modport slave (
    input  szcv_enable, alu_op, alu_a, alu_b, alu_result, alu_carry,
    input  flag_save, flag_restore, eval_en, cond,
    output flags, shadow_valid, branch_taken
  );
endinterface

// File: rtl/szcv_flag_reg.sv
// Architectural SZCV flag register with one-entry shadow copy and registered branch decision.
// Optional macro SZCV_BYPASS_EN forwards freshly derived flags into same-cycle branch evaluation.
module szcv_flag_reg #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  szcv_flag_reg_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SLR = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  function automatic logic [3:0] derive_flags(
    input logic [3:0]     op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] r,
    input logic           carry
  );
    logic s;
    logic z;
    logic c;
    logic v;
    s = r[MSB];
    z = (r == {WIDTH{1'b0}});
    case (op)
      OP_ADD, OP_SUB, OP_CMP, OP_SLL, OP_SLR, OP_SRL, OP_SRA: c = carry;
      default:                                                c = 1'b0;
    endcase
    // Overflow only exists for the signed add/subtract family.
    case (op)
      OP_ADD:         v = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      OP_SUB, OP_CMP: v = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      default:        v = 1'b0;
    endcase
    return {s, z, c, v};
  endfunction

  function automatic logic eval_cond(input logic [2:0] cd, input logic [3:0] f);
    logic res;
    case (cd)
      3'b000:  res = f[2];
      3'b001:  res = f[3] ^ f[0];
      3'b010:  res = f[2] | (f[3] ^ f[0]);
      3'b011:  res = ~f[2];
      3'b100:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [3:0] flags_r;
  logic [3:0] shadow_r;
  logic       shadow_valid_r;
  logic       branch_taken_r;

  logic [3:0] derived_s;
  logic       restore_ok_s;
  logic [3:0] flags_nxt_s;
  logic [3:0] shadow_nxt_s;
  logic       shadow_valid_nxt_s;
  logic [3:0] eval_flags_s;
  logic       branch_nxt_s;

  // Next-state selection for flags, shadow and branch decision.
  always_comb begin
    derived_s    = derive_flags(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_result, bus.alu_carry);
    restore_ok_s = bus.flag_restore & shadow_valid_r;

    if (restore_ok_s) begin
      flags_nxt_s = shadow_r;
    end else if (bus.szcv_enable) begin
      flags_nxt_s = derived_s;
    end else begin
      flags_nxt_s = flags_r;
    end

    // Save always captures pre-edge flags, which makes save+restore a swap.
    if (bus.flag_save) begin
      shadow_nxt_s       = flags_r;
      shadow_valid_nxt_s = 1'b1;
    end else if (restore_ok_s) begin
      shadow_nxt_s       = shadow_r;
      shadow_valid_nxt_s = 1'b0;
    end else begin
      shadow_nxt_s       = shadow_r;
      shadow_valid_nxt_s = shadow_valid_r;
    end

`ifdef SZCV_BYPASS_EN
    eval_flags_s = flags_nxt_s;
`else
    eval_flags_s = flags_r;
`endif

    if (bus.eval_en) begin
      branch_nxt_s = eval_cond(bus.cond, eval_flags_s);
    end else begin
      branch_nxt_s = branch_taken_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_r        <= 4'b0000;
      shadow_r       <= 4'b0000;
      shadow_valid_r <= 1'b0;
      branch_taken_r <= 1'b0;
    end else begin
      flags_r        <= flags_nxt_s;
      shadow_r       <= shadow_nxt_s;
      shadow_valid_r <= shadow_valid_nxt_s;
      branch_taken_r <= branch_nxt_s;
    end
  end

  assign bus.flags        = flags_r;
  assign bus.shadow_valid = shadow_valid_r;
  assign bus.branch_taken = branch_taken_r;

endmodule

// File: tb/tb_szcv_flag_reg.sv
// Self-checking bench for szcv_flag_reg: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_szcv_flag_reg;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  szcv_flag_reg_if #(.WIDTH(16)) bus ();

  szcv_flag_reg #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [3:0] m_flags;
  logic [3:0] m_shadow;
  logic       m_valid;
  logic       m_branch;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Flags from the arithmetic meaning of each op; results fed in are always a+b / a-b for those ops.
  function automatic logic [3:0] ref_flags(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] r,
                                           input logic carry);
    int  sa;
    int  sb;
    int  full;
    logic s, z, c, v;
    sa = $signed(a);
    sb = $signed(b);
    s  = (r >= 16'h8000);
    z  = (r == 16'h0000);
    c  = (op inside {4'd0, 4'd1, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11}) ? carry : 1'b0;
    v  = 1'b0;
    if (op == 4'd0) begin
      full = sa + sb;
      v    = (full > 32767) || (full < -32768);
    end else if (op == 4'd1 || op == 4'd5) begin
      full = sa - sb;
      v    = (full > 32767) || (full < -32768);
    end
    return {s, z, c, v};
  endfunction

  function automatic logic ref_cond(input logic [2:0] cd, input logic [3:0] f);
    logic lt;
    lt = (f[3] != f[0]);
    if (cd == 3'd0) return f[2];
    if (cd == 3'd1) return lt;
    if (cd == 3'd2) return f[2] || lt;
    if (cd == 3'd3) return !f[2];
    if (cd == 3'd4) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one cycle of inputs (called at a falling edge), advance the model, check at next falling edge.
  task automatic cyc(input logic rn, input logic en, input logic [3:0] op,
                     input logic [15:0] a, input logic [15:0] b, input logic carry,
                     input logic sv, input logic rs, input logic ev, input logic [2:0] cd);
    logic [15:0] r;
    logic [3:0]  d, nf, ns, ef;
    logic        nv, nb, rv;
    if (op == 4'd0) r = a + b;
    else if (op == 4'd1 || op == 4'd5) r = a - b;
    else r = 16'($urandom);
    rst_n            = rn;
    bus.szcv_enable  = en;
    bus.alu_op       = op;
    bus.alu_a        = a;
    bus.alu_b        = b;
    bus.alu_result   = r;
    bus.alu_carry    = carry;
    bus.flag_save    = sv;
    bus.flag_restore = rs;
    bus.eval_en      = ev;
    bus.cond         = cd;

    d  = ref_flags(op, a, b, r, carry);
    rv = rs && m_valid;
    nf = rv ? m_shadow : (en ? d : m_flags);
    ns = sv ? m_flags : m_shadow;
    nv = sv ? 1'b1 : (rv ? 1'b0 : m_valid);
`ifdef SZCV_BYPASS_EN
    ef = nf;
`else
    ef = m_flags;
`endif
    nb = ev ? ref_cond(cd, ef) : m_branch;
    if (!rn) begin
      nf = 4'b0000; ns = 4'b0000; nv = 1'b0; nb = 1'b0;
    end
    @(negedge clk);
    m_flags = nf; m_shadow = ns; m_valid = nv; m_branch = nb;
    check_eq("flags", {12'h000, bus.flags}, {12'h000, m_flags});
    check_eq("shadow_valid", {15'h0000, bus.shadow_valid}, {15'h0000, m_valid});
    check_eq("branch_taken", {15'h0000, bus.branch_taken}, {15'h0000, m_branch});
  endtask

  task automatic idle(input logic ev, input logic [2:0] cd);
    cyc(1'b1, 1'b0, 4'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, ev, cd);
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;
    m_flags = 4'b0000; m_shadow = 4'b0000; m_valid = 1'b0; m_branch = 1'b0;
    rst_n = 1'b0;
    bus.szcv_enable = 1'b0; bus.alu_op = 4'd0; bus.alu_a = 16'h0; bus.alu_b = 16'h0;
    bus.alu_result = 16'h0; bus.alu_carry = 1'b0; bus.flag_save = 1'b0;
    bus.flag_restore = 1'b0; bus.eval_en = 1'b0; bus.cond = 3'd0;
    @(negedge clk);

    // Reset with commit held high.
    cyc(1'b0, 1'b1, 4'd5, 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4);
    cyc(1'b0, 1'b1, 4'd0, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
    check_eq("rst_flags", {12'h000, bus.flags}, 16'h0000);
    check_eq("rst_valid", {15'h0000, bus.shadow_valid}, 16'h0000);
    check_eq("rst_branch", {15'h0000, bus.branch_taken}, 16'h0000);

    // CMP overflow.
    cyc(1'b1, 1'b1, 4'd5, 16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    check_eq("cmp_ovf", {12'h000, bus.flags}, 16'h0009);

    // Zero result then condition sweep.
    cyc(1'b1, 1'b1, 4'd5, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    check_eq("cmp_zero", {12'h000, bus.flags}, 16'h0006);
    idle(1'b1, 3'd0);
    check_eq("be", {15'h0000, bus.branch_taken}, 16'h0001);
    idle(1'b1, 3'd3);
    check_eq("bne", {15'h0000, bus.branch_taken}, 16'h0000);
    idle(1'b1, 3'd2);
    check_eq("ble", {15'h0000, bus.branch_taken}, 16'h0001);

    // Save, overwrite, restore, then an ignored restore.
    cyc(1'b1, 1'b0, 4'd2, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    cyc(1'b1, 1'b1, 4'd0, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    check_eq("add_s", {12'h000, bus.flags}, 16'h0008);
    cyc(1'b1, 1'b0, 4'd2, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    check_eq("restore", {12'h000, bus.flags}, 16'h0006);
    check_eq("restore_valid", {15'h0000, bus.shadow_valid}, 16'h0000);
    cyc(1'b1, 1'b0, 4'd2, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    check_eq("restore_noop", {12'h000, bus.flags}, 16'h0006);

    // Build flags=0001 in shadow, flags=1000 live, then swap.
    cyc(1'b1, 1'b1, 4'd0, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    check_eq("add_v", {12'h000, bus.flags}, 16'h0001);
    cyc(1'b1, 1'b1, 4'd0, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    cyc(1'b1, 1'b0, 4'd2, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    check_eq("swap_flags", {12'h000, bus.flags}, 16'h0001);
    check_eq("swap_valid", {15'h0000, bus.shadow_valid}, 16'h0001);
    cyc(1'b1, 1'b0, 4'd2, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    check_eq("swap_back", {12'h000, bus.flags}, 16'h0008);

    // Commit and evaluate in the same cycle from cleared flags.
    cyc(1'b0, 1'b0, 4'd2, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    cyc(1'b1, 1'b1, 4'd5, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
`ifdef SZCV_BYPASS_EN
    check_eq("bypass_be", {15'h0000, bus.branch_taken}, 16'h0001);
`else
    check_eq("nobypass_be", {15'h0000, bus.branch_taken}, 16'h0000);
`endif

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      op = 4'($urandom);
      if ($urandom_range(0, 2) == 0) op = 4'd5;
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = {a[15], 15'h7FFF};
      cyc(($urandom_range(0, 39) != 0), 1'($urandom), op, a, b, 1'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 1) == 0), 3'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
